// File: rtl/bpu_bht_if.sv
// rtl/bpu_bht_if.sv - fetch/execute-side signal bundle of the branch history table
interface bpu_bht_if;
  logic [31:0] inst_addr_i;
  logic [31:0] inst_i;
  logic        bp_result_o;
  logic [31:0] bp_jump_addr_o;
  logic        upd_valid_i;
  logic [31:0] upd_addr_i;
  logic        upd_taken_i;
  logic        upd_mispredict_i;
  logic        flush_i;
  logic [31:0] miss_cnt_o;

  modport master (
    output inst_addr_i, inst_i,
    output upd_valid_i, upd_addr_i, upd_taken_i, upd_mispredict_i, flush_i,
    input  bp_result_o, bp_jump_addr_o, miss_cnt_o
  );

  modport slave (
    input  inst_addr_i, inst_i,
    input  upd_valid_i, upd_addr_i, upd_taken_i, upd_mispredict_i, flush_i,
    output bp_result_o, bp_jump_addr_o, miss_cnt_o
  );
endinterface

// File: rtl/bpu_bht.sv
// rtl/bpu_bht.sv - direct-mapped tagged saturating-counter branch predictor
// Combinational prediction from the fetched word; trained by EX at the clock edge.
module bpu_bht #(
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 2,
  parameter int TAG_W   = 8
) (
  input  logic     clk,
  input  logic     rst,
  bpu_bht_if.slave bus
);

  localparam int IDX_W  = $clog2(ENTRIES);
  localparam int TAG_LO = 2 + IDX_W;
  localparam int TAG_HI = TAG_LO + TAG_W;

  localparam logic [CNT_W-1:0] CNT_MID = {1'b1, {(CNT_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_WNT = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [31:0]      MISS_MAX = 32'hFFFF_FFFF;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic             valid_q [ENTRIES];
  logic [TAG_W-1:0] tag_q   [ENTRIES];
  logic [CNT_W-1:0] cnt_q   [ENTRIES];
  logic [31:0]      miss_cnt_q;

  // Fetch-side decode
  logic [6:0]  opcode;
  logic [31:0] j_imm;
  logic [31:0] b_imm;
  logic [31:0] seq_pc;

  assign opcode = bus.inst_i[6:0];
  assign j_imm  = {{11{bus.inst_i[31]}}, bus.inst_i[31], bus.inst_i[19:12],
                   bus.inst_i[20], bus.inst_i[30:21], 1'b0};
  assign b_imm  = {{19{bus.inst_i[31]}}, bus.inst_i[31], bus.inst_i[7],
                   bus.inst_i[30:25], bus.inst_i[11:8], 1'b0};
  assign seq_pc = bus.inst_addr_i + 32'd4;

  // Table lookup for the fetch PC
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;
  logic             lk_taken;

  assign lk_idx   = bus.inst_addr_i[2 +: IDX_W];
  assign lk_tag   = bus.inst_addr_i[TAG_LO +: TAG_W];
  assign lk_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign lk_taken = lk_hit && cnt_q[lk_idx][CNT_W-1];

  logic        pred_taken;
  logic [31:0] pred_target;

  // Reset forces a quiet prediction so pc_reg never follows a stale target.
  always_comb begin
    pred_taken  = 1'b0;
    pred_target = seq_pc;
    case (opcode)
      OP_JAL: begin
        pred_taken  = 1'b1;
        pred_target = bus.inst_addr_i + j_imm;
      end
      OP_BRANCH: begin
        if (lk_taken) begin
          pred_taken  = 1'b1;
          pred_target = bus.inst_addr_i + b_imm;
        end
      end
      default: begin
        pred_taken  = 1'b0;
        pred_target = seq_pc;
      end
    endcase
    if (!rst) begin
      pred_taken  = 1'b0;
      pred_target = 32'd0;
    end
  end

  assign bus.bp_result_o    = pred_taken;
  assign bus.bp_jump_addr_o = pred_target;
  assign bus.miss_cnt_o     = miss_cnt_q;

  // Training-side lookup
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic [CNT_W-1:0] up_cnt;
  logic             up_hit;

  assign up_idx = bus.upd_addr_i[2 +: IDX_W];
  assign up_tag = bus.upd_addr_i[TAG_LO +: TAG_W];
  assign up_cnt = cnt_q[up_idx];
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  // Flush takes priority over training; a missed update reallocates the slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        cnt_q[i]   <= CNT_WNT;
      end
    end else if (bus.flush_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
      end
    end else if (bus.upd_valid_i) begin
      if (up_hit) begin
        if (bus.upd_taken_i && (up_cnt != CNT_MAX)) begin
          cnt_q[up_idx] <= up_cnt + 1'b1;
        end else if (!bus.upd_taken_i && (up_cnt != '0)) begin
          cnt_q[up_idx] <= up_cnt - 1'b1;
        end
      end else begin
        valid_q[up_idx] <= 1'b1;
        tag_q[up_idx]   <= up_tag;
        cnt_q[up_idx]   <= bus.upd_taken_i ? CNT_MID : CNT_WNT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      miss_cnt_q <= 32'd0;
    end else if (bus.upd_valid_i && bus.upd_mispredict_i && (miss_cnt_q != MISS_MAX)) begin
      miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  // Address bits outside index/tag do not take part in training.
  logic unused_upd_bits;
  if (TAG_HI < 32) begin : g_upd_hi
    assign unused_upd_bits = ^{bus.upd_addr_i[31:TAG_HI], bus.upd_addr_i[1:0]};
  end else begin : g_upd_lo
    assign unused_upd_bits = ^bus.upd_addr_i[1:0];
  end

endmodule

// File: tb/tb_bpu_bht.sv
// tb/tb_bpu_bht.sv - scoreboard bench for bpu_bht against a table-level reference model
module tb_bpu_bht;

  localparam int K_JAL = 0;
  localparam int K_BR  = 1;
  localparam int K_OTH = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  bpu_bht_if bus_if ();

  bpu_bht dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  typedef struct {
    logic        res;
    logic [31:0] addr;
    logic [31:0] miss;
    string       name;
  } exp_t;

  exp_t sb[$];
  int vectors     = 0;
  int miscompares = 0;

  // Reference model: 16 entries, counters 0..3, 8-bit tags
  bit          mv   [16];
  int          mtag [16];
  int          mcnt [16];
  logic [31:0] mmiss;

  function automatic int idx_of(logic [31:0] a);
    return int'((a >> 2) & 32'hF);
  endfunction

  function automatic int tag_of(logic [31:0] a);
    return int'((a >> 6) & 32'hFF);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) begin
      mv[i]   = 1'b0;
      mtag[i] = 0;
      mcnt[i] = 1;
    end
    mmiss = 32'd0;
  endfunction

  function automatic logic [31:0] enc_b(int imm);
    logic [12:0] v;
    v = imm[12:0];
    return {v[12], v[10:5], 5'd3, 5'd4, 3'b000, v[4:1], v[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(int imm);
    logic [20:0] v;
    v = imm[20:0];
    return {v[20], v[10:1], v[11], v[19:12], 5'd1, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_other();
    logic [6:0]  ops [5];
    logic [31:0] r;
    ops = '{7'b1100111, 7'b0110011, 7'b0010011, 7'b0000011, 7'b0110111};
    r = $urandom;
    r[6:0] = ops[$urandom_range(0, 4)];
    return r;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One cycle of stimulus: drive, predict from the model's pre-edge state, then train it.
  task automatic step(int kind, logic [31:0] pc, int imm, bit uv, logic [31:0] ua,
                      bit ut, bit um, bit fl, bit rs, string nm);
    exp_t e;
    int   i;
    bit   hit;
    @(posedge clk);
    #1;
    rst = rs;
    bus_if.inst_addr_i      = pc;
    bus_if.inst_i           = (kind == K_JAL) ? enc_j(imm) : (kind == K_BR) ? enc_b(imm) : enc_other();
    bus_if.upd_valid_i      = uv;
    bus_if.upd_addr_i       = ua;
    bus_if.upd_taken_i      = ut;
    bus_if.upd_mispredict_i = um;
    bus_if.flush_i          = fl;
    e.name = nm;
    if (!rs) begin
      model_reset();
      e.res  = 1'b0;
      e.addr = 32'd0;
      e.miss = 32'd0;
    end else begin
      e.miss = mmiss;
      if (kind == K_JAL) begin
        e.res  = 1'b1;
        e.addr = pc + imm;
      end else if (kind == K_BR) begin
        i   = idx_of(pc);
        hit = mv[i] && (mtag[i] == tag_of(pc)) && (mcnt[i] >= 2);
        e.res  = hit;
        e.addr = hit ? pc + imm : pc + 4;
      end else begin
        e.res  = 1'b0;
        e.addr = pc + 4;
      end
      if (fl) begin
        for (int k = 0; k < 16; k++) mv[k] = 1'b0;
      end else if (uv) begin
        i = idx_of(ua);
        if (mv[i] && mtag[i] == tag_of(ua)) begin
          mcnt[i] = ut ? ((mcnt[i] == 3) ? 3 : mcnt[i] + 1) : ((mcnt[i] == 0) ? 0 : mcnt[i] - 1);
        end else begin
          mv[i]   = 1'b1;
          mtag[i] = tag_of(ua);
          mcnt[i] = ut ? 2 : 1;
        end
      end
      if (uv && um && mmiss != 32'hFFFF_FFFF) mmiss = mmiss + 32'd1;
    end
    sb.push_back(e);
  endtask

  task automatic idle(string nm);
    step(K_OTH, 32'h0000_1000, 0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, nm);
  endtask

  task automatic br_look(logic [31:0] pc, int imm, string nm);
    step(K_BR, pc, imm, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, nm);
  endtask

  task automatic train(logic [31:0] ua, bit ut, string nm);
    step(K_OTH, 32'h0000_2000, 0, 1'b1, ua, ut, 1'b0, 1'b0, 1'b1, nm);
  endtask

  // Monitor: compares the oldest expectation against the DUT at each falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk({e.name, ".result"}, {31'd0, bus_if.bp_result_o}, {31'd0, e.res});
        chk({e.name, ".target"}, bus_if.bp_jump_addr_o, e.addr);
        chk({e.name, ".miss"}, bus_if.miss_cnt_o, e.miss);
      end
    end
  end

  initial begin
    bus_if.inst_addr_i      = 32'd0;
    bus_if.inst_i           = 32'd0;
    bus_if.upd_valid_i      = 1'b0;
    bus_if.upd_addr_i       = 32'd0;
    bus_if.upd_taken_i      = 1'b0;
    bus_if.upd_mispredict_i = 1'b0;
    bus_if.flush_i          = 1'b0;
    model_reset();

    step(K_JAL, 32'h80, 32'h100, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, "rst_hold");
    step(K_JAL, 32'h80, 32'h100, 1'b1, 32'h200, 1'b1, 1'b1, 1'b0, 1'b0, "rst_hold_upd");
    step(K_JAL, 32'h80, 32'h100, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, "jal_fwd");
    step(K_JAL, 32'h1000, -64, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, "jal_back");
    step(K_OTH, 32'h84, 0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, "non_branch");

    br_look(32'h200, -8, "cold_br");
    step(K_BR, 32'h200, -8, 1'b1, 32'h200, 1'b1, 1'b0, 1'b0, 1'b1, "same_cycle_old");
    br_look(32'h200, -8, "trained");

    for (int k = 0; k < 5; k++) train(32'h200, 1'b1, "sat_up");
    train(32'h200, 1'b0, "sat_dn1");
    br_look(32'h200, -8, "after_one_nt");
    train(32'h200, 1'b0, "sat_dn2");
    train(32'h200, 1'b0, "sat_dn3");
    br_look(32'h200, -8, "after_three_nt");
    train(32'h200, 1'b0, "sat_floor1");
    train(32'h200, 1'b0, "sat_floor2");
    train(32'h200, 1'b1, "floor_up");
    br_look(32'h200, -8, "floor_held");

    train(32'h200, 1'b1, "alias_train");
    br_look(32'h200, -8, "alias_owner");
    br_look(32'h240, 16, "alias_tagmiss");
    train(32'h240, 1'b0, "alias_evict");
    br_look(32'h200, -8, "alias_evicted");

    train(32'h300, 1'b1, "flush_train");
    br_look(32'h300, 32, "flush_before");
    step(K_BR, 32'h300, 32, 1'b1, 32'h300, 1'b1, 1'b1, 1'b1, 1'b1, "flush_and_upd");
    br_look(32'h300, 32, "flush_after");

    for (int k = 0; k < 3; k++)
      step(K_OTH, 32'h400, 0, 1'b1, 32'h400, 1'b0, 1'b1, 1'b0, 1'b1, "mis_qual");
    step(K_OTH, 32'h400, 0, 1'b0, 32'h400, 1'b0, 1'b1, 1'b0, 1'b1, "mis_unqual");
    idle("mis_count");

    @(negedge clk);
    #1;
    force dut.miss_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.miss_cnt_q;
    mmiss = 32'hFFFF_FFFF;
    step(K_OTH, 32'h400, 0, 1'b1, 32'h400, 1'b1, 1'b1, 1'b0, 1'b1, "mis_at_max");
    idle("mis_sat_hold");

    for (int n = 0; n < 300; n++) begin
      int          kind;
      int          imm;
      logic [31:0] pc;
      logic [31:0] ua;
      kind = $urandom_range(0, 2);
      imm  = int'($urandom_range(0, 2047)) * 2 - 2048;
      pc   = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
      ua   = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
      step(kind, pc, imm, 1'($urandom_range(0, 1)), ua, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), ($urandom_range(0, 29) == 0), 1'b1, "rand");
    end

    idle("pre_async");
    step(K_JAL, 32'h80, 32'h100, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, "async_rst");
    idle("rst_release");
    step(K_BR, 32'h200, -8, 1'b1, 32'h200, 1'b1, 1'b0, 1'b0, 1'b1, "post_rst_alloc");
    br_look(32'h200, -8, "post_rst_taken");
    idle("tail");

    for (int k = 0; k < 20 && sb.size() > 0; k++) @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
